vga_tile_display: RTL and testbench
===================================

// Module: vga_tile_display
// PURPOSE
//  Parametrised VGA timing generator and tile renderer, single clock domain.
//  - Derives a pixel-tick enable from clk; there are no generated clocks.
//  - Reads a tile framebuffer through a 1-cycle-latency synchronous read port.
//  - Drives RGB444 plus HS/VS with a fixed 2-tick pipeline delay.
//  - Sits between the game logic's tile RAM and the DE0 VGA DAC pins.
// PARAMETERS
//  CLK_DIV     2    clk cycles per pixel tick (50 MHz -> 25 MHz); must be >= 2
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BP        48   horizontal back porch, pixels
//  V_ACTIVE    480  visible lines
//  V_FP        10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BP        33   vertical back porch, lines
//  TILE_SHIFT  4    log2 of tile edge in pixels (16x16 tiles)
//  ADDR_W      11   tile address width; must hold TILES_X*TILES_Y-1
//  MONO        1    1: tile_data[0] replicated to all 12 colour bits; 0: tile_data is {R,G,B} 4b each
//  SYNC_POL    0    sync active level; 0 = active-low
// PORTS
//  clk          in   1       system clock, 50 MHz
//  rst          in   1       asynchronous reset, active-high
//  tile_rd_en   out  1       read strobe, one clk wide, on the pixel tick of each active pixel
//  tile_addr    out  ADDR_W  tile index = (h>>TILE_SHIFT) + (v>>TILE_SHIFT)*TILES_X
//  tile_data    in   12      tile colour, valid on the clk after tile_rd_en
//  cursor_addr  in   ADDR_W  highlighted tile (only present with VGA_TILE_CURSOR_EN)
//  red_out      out  4       pixel red
//  green_out    out  4       pixel green
//  blue_out     out  4       pixel blue
//  h_sync_out   out  1       horizontal sync, SYNC_POL level when asserted
//  v_sync_out   out  1       vertical sync, SYNC_POL level when asserted
//  h_position   out  12      current h counter, stage 0
//  v_position   out  11      current v counter, stage 0
//  frame_start  out  1       one-clk pulse on the tick where h=0 and v=0
// BEHAVIOUR
//  Derived constants:
//   H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//   TILES_X = H_ACTIVE>>TILE_SHIFT.
//  Pixel tick:
//   - div counter runs 0..CLK_DIV-1; tick asserts when it equals CLK_DIV-1.
//   - All state below advances only on a tick.
//  Stage 0 counters:
//   - h runs 0..H_TOTAL-1 and wraps to 0.
//   - v increments on each h wrap and wraps to 0 after V_TOTAL-1.
//   - active = (h<H_ACTIVE)&&(v<V_ACTIVE).
//   - hs asserted when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - vs asserted when v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//  Memory access:
//   - tile_rd_en = tick & active.
//   - tile_addr is combinational from stage-0 h/v; it holds its last value in blanking.
//  Stage 1: active, hs and vs are delayed one tick; tile_data is sampled on the clk after tile_rd_en.
//  Stage 2 output registers, loaded on tick:
//   - rgb = stage-1 active ? colour : 12'h000.
//   - h_sync_out and v_sync_out are registered here, so sync and RGB stay aligned.
//   - Total latency from counter to pins is 2 ticks.
//  Address arithmetic:
//   - Multiply by TILES_X is done as unsigned at ADDR_W bits.
//   - When TILES_X is a power of 2 it is a shift; otherwise synthesis infers the multiply.
//  Reset (asserted at any time, including mid-line):
//   - div, h, v and every pipeline stage clear to 0.
//   - rgb outputs = 0, tile_rd_en = 0, frame_start = 0.
//   - h_sync_out and v_sync_out go to their deasserted level (~SYNC_POL).
//   - First tick after release is h=0, v=0; frame_start pulses on it.
//  Boundaries: the last active pixel h=H_ACTIVE-1 reads a tile; h=H_ACTIVE does not.
//  tile_data is ignored on clks that do not follow tile_rd_en.
// CONFIGURATION
//  VGA_TILE_CURSOR_EN defined:
//   - cursor_addr port exists.
//   - The stage-1 address is compared with cursor_addr.
//   - On a match, stage-2 rgb = ~colour (bitwise invert) while active.
//  VGA_TILE_CURSOR_EN undefined: no port, no comparator, colour is passed unmodified.
// STRUCTURE
//  vga_pkg:
//   - VGA_640x480 timing constants.
//   - RGB444 struct typedef.
//   - SYNC_POL localparams.
//  Sub-module vga_timing:
//   - Contains the divider, h/v counters and hs/vs/active decode.
//   - Reusable by later text and sprite engines.
//  The top level holds the address generation, the pipeline and the colour/cursor logic.
// TESTING
//  1. Reset then free-run one frame: hs period = 800 ticks, 96 asserted; vs period = 525 lines, 2 asserted; frame_start exactly once.
//  2. Model RAM returns tile_data = tile_addr[11:0], MONO=0: pixel (16,16) shows RGB 12'h029 two ticks after counter (16,16).
//  3. MONO=1, only tile 1199 set: white only for h 624..639, v 464..479; rgb = 0 in all blanking.
//  4. Assert rst at h=300, v=200 for 3 clks: outputs clear immediately; after release frame_start pulses and h restarts at 0.
//  5. With VGA_TILE_CURSOR_EN, cursor_addr = 41, all tiles 12'h0F0: tile (1,1) pixels = 12'hF0F, others 12'h0F0.
//  6. CLK_DIV=4 build: tile_rd_en high 1 clk in 4 during active; line = 3200 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, the RGB444 pixel type and the
// sync polarity encodings used by the tile renderer and later display engines.
package vga_pkg;

    localparam int VGA_640X480_H_ACTIVE = 640;
    localparam int VGA_640X480_H_FP     = 16;
    localparam int VGA_640X480_H_SYNC   = 96;
    localparam int VGA_640X480_H_BP     = 48;
    localparam int VGA_640X480_V_ACTIVE = 480;
    localparam int VGA_640X480_V_FP     = 10;
    localparam int VGA_640X480_V_SYNC   = 2;
    localparam int VGA_640X480_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-tick divider, h/v counters and the active/hs/vs
// decode of the current (stage-0) raster position. Syncs are active-high here;
// polarity is applied by whoever drives the pins.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_640X480_H_ACTIVE,
    parameter int H_FP     = VGA_640X480_H_FP,
    parameter int H_SYNC   = VGA_640X480_H_SYNC,
    parameter int H_BP     = VGA_640X480_H_BP,
    parameter int V_ACTIVE = VGA_640X480_V_ACTIVE,
    parameter int V_FP     = VGA_640X480_V_FP,
    parameter int V_SYNC   = VGA_640X480_V_SYNC,
    parameter int V_BP     = VGA_640X480_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        tick,
    output logic [11:0] h_p0,
    output logic [10:0] v_p0,
    output logic        vld_p0,
    output logic        hs_p0,
    output logic        vs_p0
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    // Free-running clk divider producing the one-clk pixel tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    // Raster counters: h wraps each line, v advances on every h wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (tick) begin
            if (h_p0 == H_LAST) begin
                h_p0 <= '0;
                v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
            end else begin
                h_p0 <= h_p0 + 1'b1;
            end
        end
    end

    assign vld_p0 = (h_p0 < H_ACT_W) && (v_p0 < V_ACT_W);
    assign hs_p0  = (h_p0 >= HS_START) && (h_p0 < HS_END);
    assign vs_p0  = (v_p0 >= VS_START) && (v_p0 < VS_END);

endmodule

// File: rtl/vga_tile_display.sv
// VGA tile renderer: generates tile RAM reads from the raster position and
// drives RGB444 plus syncs two pixel ticks after the counters.
// Optional feature macro: VGA_TILE_CURSOR_EN adds cursor_addr and inverts the
// colour of the highlighted tile.
module vga_tile_display
    import vga_pkg::*;
#(
    parameter int   CLK_DIV    = 2,
    parameter int   H_ACTIVE   = VGA_640X480_H_ACTIVE,
    parameter int   H_FP       = VGA_640X480_H_FP,
    parameter int   H_SYNC     = VGA_640X480_H_SYNC,
    parameter int   H_BP       = VGA_640X480_H_BP,
    parameter int   V_ACTIVE   = VGA_640X480_V_ACTIVE,
    parameter int   V_FP       = VGA_640X480_V_FP,
    parameter int   V_SYNC     = VGA_640X480_V_SYNC,
    parameter int   V_BP       = VGA_640X480_V_BP,
    parameter int   TILE_SHIFT = 4,
    parameter int   ADDR_W     = 11,
    parameter int   MONO       = 1,
    parameter logic SYNC_POL   = SYNC_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              rst,
    output logic              tile_rd_en,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic [11:0]       tile_data,
`ifdef VGA_TILE_CURSOR_EN
    input  logic [ADDR_W-1:0] cursor_addr,
`endif
    output logic [3:0]        red_out,
    output logic [3:0]        green_out,
    output logic [3:0]        blue_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic [11:0]       h_position,
    output logic [10:0]       v_position,
    output logic              frame_start
);

    localparam int TILES_X = H_ACTIVE >> TILE_SHIFT;
    localparam logic [ADDR_W-1:0] TILES_X_A = ADDR_W'(TILES_X);

    // Mono tiles light all twelve colour bits from bit 0.
    function automatic rgb444_t expand_colour(input logic [11:0] d);
        if (MONO != 0) return rgb444_t'({12{d[0]}});
        else           return rgb444_t'(d);
    endfunction

    logic              tick;
    logic [11:0]       h_p0;
    logic [10:0]       v_p0;
    logic              vld_p0, hs_p0, vs_p0;
    logic [ADDR_W-1:0] addr_calc_p0, addr_hold;
    logic              vld_p1, hs_p1, vs_p1, rd_p1;
    rgb444_t           colour_p1, pix_p1, rgb_p2;

    vga_timing #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .tick(tick), .h_p0(h_p0), .v_p0(v_p0),
        .vld_p0(vld_p0), .hs_p0(hs_p0), .vs_p0(vs_p0)
    );

    // ---- stage 0: address generation and memory request ----
    assign addr_calc_p0 = ADDR_W'(h_p0 >> TILE_SHIFT) + ADDR_W'(v_p0 >> TILE_SHIFT) * TILES_X_A;
    assign tile_addr    = vld_p0 ? addr_calc_p0 : addr_hold;
    assign tile_rd_en   = tick & vld_p0;
    assign frame_start  = tick && (h_p0 == 12'd0) && (v_p0 == 11'd0);
    assign h_position   = h_p0;
    assign v_position   = v_p0;

    // Remember the last requested address so tile_addr is stable in blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             addr_hold <= '0;
        else if (tile_rd_en) addr_hold <= addr_calc_p0;
    end

    // ---- stage 1: control delayed one tick, colour captured from the RAM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else if (tick) begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
        end
    end

    // Read data is only trusted on the clk right after a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1     <= 1'b0;
            colour_p1 <= '0;
        end else begin
            rd_p1 <= tile_rd_en;
            if (rd_p1) colour_p1 <= expand_colour(tile_data);
        end
    end

`ifdef VGA_TILE_CURSOR_EN
    logic [ADDR_W-1:0] addr_p1;

    // Address of the pixel currently held in stage 1, for the cursor compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             addr_p1 <= '0;
        else if (tile_rd_en) addr_p1 <= tile_addr;
    end

    assign pix_p1 = (addr_p1 == cursor_addr) ? ~colour_p1 : colour_p1;
`else
    assign pix_p1 = colour_p1;
`endif

    // ---- stage 2: output registers, syncs kept aligned with RGB ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_p2     <= '0;
            h_sync_out <= ~SYNC_POL;
            v_sync_out <= ~SYNC_POL;
        end else if (tick) begin
            rgb_p2     <= vld_p1 ? pix_p1 : rgb444_t'(12'h000);
            h_sync_out <= hs_p1 ? SYNC_POL : ~SYNC_POL;
            v_sync_out <= vs_p1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign red_out   = rgb_p2.r;
    assign green_out = rgb_p2.g;
    assign blue_out  = rgb_p2.b;

endmodule

// File: tb/tb_vga_tile_display.sv
// Bench for vga_tile_display on a reduced 48x32 raster (64x40 total) with
// 16x16 tiles (3 tiles per row, 6 tiles): two CLK_DIV=2 instances (colour
// and mono) and one CLK_DIV=4 instance, each with its own model tile RAM.
module tb_vga_tile_display;

    localparam int HA = 48, HF = 4, HS = 8, HB = 4;
    localparam int VA = 32, VF = 2, VS = 2, VB = 4;
`ifdef VGA_TILE_CURSOR_EN
    localparam logic [11:0] EXP_T4 = 12'hFFB;
`else
    localparam logic [11:0] EXP_T4 = 12'h004;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd0, rd1, rd4;
    logic [10:0] a0, a1, a4;
    logic [11:0] d0, d1, d4;
    logic [3:0]  r0, g0, b0, r1, g1, b1, r4, g4, b4;
    logic        hs0, vs0, hs1, vs1, hs4, vs4;
    logic [11:0] hp0, hp1, hp4;
    logic [10:0] vp0, vp1, vp4;
    logic        fs0, fs1, fs4;

    vga_tile_display #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MONO(0)) u_d0 (
        .clk(clk), .rst(rst), .tile_rd_en(rd0), .tile_addr(a0), .tile_data(d0),
`ifdef VGA_TILE_CURSOR_EN
        .cursor_addr(11'd4),
`endif
        .red_out(r0), .green_out(g0), .blue_out(b0), .h_sync_out(hs0), .v_sync_out(vs0),
        .h_position(hp0), .v_position(vp0), .frame_start(fs0));

    vga_tile_display #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MONO(1)) u_d1 (
        .clk(clk), .rst(rst), .tile_rd_en(rd1), .tile_addr(a1), .tile_data(d1),
`ifdef VGA_TILE_CURSOR_EN
        .cursor_addr(11'h7FF),
`endif
        .red_out(r1), .green_out(g1), .blue_out(b1), .h_sync_out(hs1), .v_sync_out(vs1),
        .h_position(hp1), .v_position(vp1), .frame_start(fs1));

    vga_tile_display #(.CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MONO(0)) u_d4 (
        .clk(clk), .rst(rst), .tile_rd_en(rd4), .tile_addr(a4), .tile_data(d4),
`ifdef VGA_TILE_CURSOR_EN
        .cursor_addr(11'h7FF),
`endif
        .red_out(r4), .green_out(g4), .blue_out(b4), .h_sync_out(hs4), .v_sync_out(vs4),
        .h_position(hp4), .v_position(vp4), .frame_start(fs4));

    // Model RAMs: one-clk read latency, junk on data when not read.
    always @(posedge clk) d0 <= rd0 ? {1'b0, a0} : 12'hFFF;
    always @(posedge clk) d1 <= rd1 ? ((a1 == 11'd5) ? 12'h001 : 12'h000) : 12'hFFF;
    always @(posedge clk) d4 <= rd4 ? {1'b0, a4} : 12'hFFF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int fs_cnt = 0, hs_lo = 0, hs_edges = 0, hs_first = -1, hs_second = -1;
        int vs_lo = 0, vs_edges = 0, rd_cnt = 0, blank_nz0 = 0, blank_nz1 = 0;
        int white1 = 0, other1 = 0, rd4_line0 = 0, hs4_first = -1, hs4_second = -1;
        int n = 0;
        logic hs0_prev = 1'b1, vs0_prev = 1'b1, hs4_prev = 1'b1;
        logic rd_last = 1'b0, rd_past = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rgb", {r0, g0, b0}, 12'h000);
        check("rst_hs", hs0, 1'b1);
        check("rst_vs", vs0, 1'b1);
        check("rst_rd", rd0, 1'b0);
        check("rst_fs", fs0, 1'b0);
        check("rst_h", hp0, 12'd0);
        rst = 1'b0;

        // One full frame of the CLK_DIV=2 instances (2560 ticks = 5120 clks).
        for (int i = 0; i < 5120; i++) begin
            @(negedge clk);
            fs_cnt += int'(fs0);
            rd_cnt += int'(rd0);
            if (!hs0) hs_lo++;
            if (!vs0) vs_lo++;
            if (hs0_prev && !hs0) begin
                hs_edges++;
                if (hs_first < 0) hs_first = i;
                else if (hs_second < 0) hs_second = i;
            end
            if (vs0_prev && !vs0) vs_edges++;
            if (hs4_prev && !hs4) begin
                if (hs4_first < 0) hs4_first = i;
                else if (hs4_second < 0) hs4_second = i;
            end
            hs0_prev = hs0;
            vs0_prev = vs0;
            hs4_prev = hs4;
            if ((hp0 >= 12'd50 || hp0 < 12'd2 || vp0 >= 11'd32) && {r0, g0, b0} != 12'h000) blank_nz0++;
            if ((hp1 >= 12'd50 || hp1 < 12'd2 || vp1 >= 11'd32) && {r1, g1, b1} != 12'h000) blank_nz1++;
            if ({r1, g1, b1} == 12'hFFF) white1++;
            else if ({r1, g1, b1} != 12'h000) other1++;
            if (vp4 == 11'd0 && rd4) rd4_line0++;
            if (hp0 == 12'd47 && vp0 == 11'd5) rd_last |= rd0;
            if (hp0 == 12'd48 && vp0 == 11'd5) rd_past |= rd0;
            if (hp0 == 12'd17 && vp0 == 11'd16) check("px_15_16", {r0, g0, b0}, 12'h003);
            if (hp0 == 12'd18 && vp0 == 11'd16) check("px_16_16", {r0, g0, b0}, EXP_T4);
            if (hp0 == 12'd49 && vp0 == 11'd31) check("px_47_31", {r0, g0, b0}, 12'h005);
            if (hp0 == 12'd53 && vp0 == 11'd3)  check("hs_before", hs0, 1'b1);
            if (hp0 == 12'd54 && vp0 == 11'd3)  check("hs_start", hs0, 1'b0);
            if (hp1 == 12'd33 && vp1 == 11'd16) check("mono_31_16", {r1, g1, b1}, 12'h000);
            if (hp1 == 12'd34 && vp1 == 11'd16) check("mono_32_16", {r1, g1, b1}, 12'hFFF);
            if (hp1 == 12'd49 && vp1 == 11'd31) check("mono_47_31", {r1, g1, b1}, 12'hFFF);
            if (hp1 == 12'd50 && vp1 == 11'd31) check("mono_48_31", {r1, g1, b1}, 12'h000);
            if (hp4 == 12'd17 && vp4 == 11'd0)  check("div4_px15", {r4, g4, b4}, 12'h000);
            if (hp4 == 12'd18 && vp4 == 11'd0)  check("div4_px16", {r4, g4, b4}, 12'h001);
        end

        check("frame_start_cnt", fs_cnt, 1);
        check("hs_low_clks", hs_lo, 640);
        check("hs_pulses", hs_edges, 40);
        check("hs_period", hs_second - hs_first, 128);
        check("vs_low_clks", vs_lo, 256);
        check("vs_pulses", vs_edges, 1);
        check("rd_per_frame", rd_cnt, 1536);
        check("rd_last_px", rd_last, 1'b1);
        check("rd_past_px", rd_past, 1'b0);
        check("blank_rgb0", blank_nz0, 0);
        check("blank_rgb1", blank_nz1, 0);
        check("mono_white", white1, 512);
        check("mono_other", other1, 0);
        check("div4_rd_line", rd4_line0, 48);
        check("div4_line_clks", hs4_second - hs4_first, 256);

        // Reset asserted mid-line.
        while (!(hp0 == 12'd30 && vp0 == 11'd20) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("reach_30_20", n < 6000, 1'b1);
        check("pre_rst_rgb", {r0, g0, b0}, EXP_T4);
        rst = 1'b1;
        #1;
        check("mid_rst_rgb", {r0, g0, b0}, 12'h000);
        check("mid_rst_h", hp0, 12'd0);
        check("mid_rst_v", vp0, 11'd0);
        check("mid_rst_hs", hs0, 1'b1);
        check("mid_rst_rd", rd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fs", fs0, 1'b1);
        check("post_rst_h0", hp0, 12'd0);
        @(negedge clk);
        check("post_rst_fs_end", fs0, 1'b0);
        check("post_rst_h1", hp0, 12'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
